// File: rtl/vend_sequencer.sv
// Drink vending transaction controller: accumulates coin credit, validates
// selections against prices, handshakes the dispenser, then pays change coin-by-coin.
module vend_sequencer #(
  parameter int unsigned PRICE0     = 10,
  parameter int unsigned PRICE1     = 15,
  parameter int unsigned PRICE2     = 20,
  parameter int unsigned PRICE3     = 25,
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  input  logic          sel_valid,
  input  logic [1:0]    sel_drink,
  input  logic          cancel,
  output logic          disp_req,
  output logic [1:0]    disp_drink,
  input  logic          disp_ack,
  output logic          chg_req,
  output logic [1:0]    chg_coin,
  input  logic          chg_ack,
  output logic [CW-1:0] total_coin,
  output logic [3:0]    can_buy,
  output logic          coin_reject,
  output logic          sel_reject,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] credit;

  function automatic logic [CW-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = CW'(1);
      2'b01:   coin_value = CW'(5);
      2'b10:   coin_value = CW'(10);
      default: coin_value = CW'(50);
    endcase
  endfunction

  function automatic logic [CW-1:0] price_of(input logic [1:0] drink);
    case (drink)
      2'd0:    price_of = CW'(PRICE0);
      2'd1:    price_of = CW'(PRICE1);
      2'd2:    price_of = CW'(PRICE2);
      default: price_of = CW'(PRICE3);
    endcase
  endfunction

  // Greedy change: largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] change_code(input logic [CW-1:0] amount);
    if (amount >= CW'(50))      change_code = 2'b11;
    else if (amount >= CW'(10)) change_code = 2'b10;
    else if (amount >= CW'(5))  change_code = 2'b01;
    else                        change_code = 2'b00;
  endfunction

  logic [CW:0]   coin_sum;
  logic          coin_fits;
  logic [CW-1:0] sel_price;
  logic          sel_ok;
  logic [1:0]    next_change;
  logic [CW-1:0] credit_after_change;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    coin_sum            = {1'b0, credit} + {1'b0, coin_value(coin_type)};
    coin_fits           = coin_sum <= (CW+1)'(MAX_CREDIT);
    sel_price           = price_of(sel_drink);
    sel_ok              = credit >= sel_price;
    next_change         = change_code(credit);
    credit_after_change = credit - coin_value(next_change);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      disp_req    <= 1'b0;
      disp_drink  <= 2'b00;
      chg_req     <= 1'b0;
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (credit != '0) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
            end
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (sel_ok) begin
              credit     <= credit - sel_price;
              disp_drink <= sel_drink;
              disp_req   <= 1'b1;
              state      <= DISPENSE;
            end else begin
              sel_reject <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits) credit <= coin_sum[CW-1:0];
            else           coin_reject <= 1'b1;
          end
        end

        DISPENSE: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          if (disp_ack) begin
            disp_req <= 1'b0;
            if (credit != '0) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        CHANGE: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          if (chg_req && chg_ack) begin
            credit <= credit_after_change;
            if (credit_after_change == '0) begin
              chg_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        default: begin
          state    <= IDLE;
          disp_req <= 1'b0;
          chg_req  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    can_buy = 4'b0000;
    if (state == IDLE) begin
      for (int i = 0; i < 4; i++) can_buy[i] = credit >= price_of(2'(i));
    end
  end

  assign chg_coin   = chg_req ? next_change : 2'b00;
  assign total_coin = credit;
  assign busy       = state != IDLE;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus random traffic,
// compared each cycle against a credit/phase reference model.
module tb_vend_sequencer;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, coin_valid, sel_valid, cancel, disp_ack, chg_ack;
  logic [1:0]    coin_type, sel_drink;
  logic          disp_req, chg_req, coin_reject, sel_reject, busy;
  logic [1:0]    disp_drink, chg_coin;
  logic [CW-1:0] total_coin;
  logic [3:0]    can_buy;

  vend_sequencer dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_drink(sel_drink), .cancel(cancel),
    .disp_req(disp_req), .disp_drink(disp_drink), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .total_coin(total_coin), .can_buy(can_buy),
    .coin_reject(coin_reject), .sel_reject(sel_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  int price [4] = '{10, 15, 20, 25};
  int value [4] = '{1, 5, 10, 50};

  // Reference model: credit in plain integers and what the machine is doing.
  int m_credit, m_drink;
  bit m_dispensing, m_refunding, m_creject, m_sreject;

  int total = 0;
  int bad   = 0;

  function automatic int greedy_code(input int amount);
    if (amount >= 50) return 3;
    if (amount >= 10) return 2;
    if (amount >= 5)  return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit cv, input int ct, input bit sv,
                              input int sd, input bit cn, input bit da, input bit ca);
    m_creject = 0;
    m_sreject = 0;
    if (rst) begin
      m_credit = 0; m_drink = 0; m_dispensing = 0; m_refunding = 0;
    end else if (m_dispensing) begin
      m_creject = cv;
      m_sreject = sv;
      if (da) begin
        m_dispensing = 0;
        m_refunding  = m_credit > 0;
      end
    end else if (m_refunding) begin
      m_creject = cv;
      m_sreject = sv;
      if (ca) begin
        m_credit -= value[greedy_code(m_credit)];
        if (m_credit == 0) m_refunding = 0;
      end
    end else if (cn) begin
      m_creject = cv;
      if (m_credit > 0) m_refunding = 1;
    end else if (sv) begin
      m_creject = cv;
      if (m_credit >= price[sd]) begin
        m_credit    -= price[sd];
        m_drink      = sd;
        m_dispensing = 1;
      end else begin
        m_sreject = 1;
      end
    end else if (cv) begin
      if (m_credit + value[ct] <= 100) m_credit += value[ct];
      else m_creject = 1;
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_buy;
    bit idle;
    idle = !m_dispensing && !m_refunding;
    for (int i = 0; i < 4; i++) exp_buy[i] = idle && (m_credit >= price[i]);
    check("total_coin", 32'(total_coin), 32'(m_credit));
    check("disp_req", 32'(disp_req), 32'(m_dispensing));
    check("disp_drink", 32'(disp_drink), 32'(m_drink));
    check("chg_req", 32'(chg_req), 32'(m_refunding));
    check("chg_coin", 32'(chg_coin), m_refunding ? 32'(greedy_code(m_credit)) : 32'd0);
    check("can_buy", 32'(can_buy), 32'(exp_buy));
    check("coin_reject", 32'(coin_reject), 32'(m_creject));
    check("sel_reject", 32'(sel_reject), 32'(m_sreject));
    check("busy", 32'(busy), 32'(!idle));
  endtask

  // One clock cycle: drive inputs, clock edge, advance the model, sample #1 later.
  task automatic step(input bit rst, input bit cv, input int ct, input bit sv,
                      input int sd, input bit cn, input bit da, input bit ca);
    reset = rst; coin_valid = cv; coin_type = 2'(ct);
    sel_valid = sv; sel_drink = 2'(sd); cancel = cn;
    disp_ack = da; chg_ack = ca;
    @(posedge clk);
    model_update(rst, cv, ct, sv, sd, cn, da, ca);
    #1;
    compare_all();
  endtask

  task automatic coin(input int ct);           step(0, 1, ct, 0, 0, 0, 0, 0); endtask
  task automatic sel(input int sd);            step(0, 0, 0, 1, sd, 0, 0, 0); endtask
  task automatic tick(input bit da, input bit ca); step(0, 0, 0, 0, 0, 0, da, ca); endtask
  task automatic do_cancel();                  step(0, 0, 0, 0, 0, 1, 0, 0); endtask

  initial begin
    m_credit = 0; m_drink = 0; m_dispensing = 0; m_refunding = 0;
    m_creject = 0; m_sreject = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_total", 32'(total_coin), 32'd0);

    // 10+5+10 buys drink 3 exactly, no change
    coin(2); coin(1); coin(2);
    check("s1_total", 32'(total_coin), 32'd25);
    check("s1_can_buy", 32'(can_buy), 32'b1111);
    sel(3);
    check("s1_disp_req", 32'(disp_req), 32'd1);
    check("s1_disp_drink", 32'(disp_drink), 32'd3);
    tick(1, 0);
    check("s1_idle", 32'(busy), 32'd0);
    check("s1_no_chg", 32'(chg_req), 32'd0);

    // 50 buys drink 0, ack on 3rd request cycle, change 4x10
    coin(3);
    sel(0);
    tick(0, 0); tick(0, 0);
    check("s2_disp_held", 32'(disp_req), 32'd1);
    tick(1, 0);
    check("s2_chg_req", 32'(chg_req), 32'd1);
    check("s2_chg_coin", 32'(chg_coin), 32'd2);
    check("s2_total40", 32'(total_coin), 32'd40);
    for (int i = 0; i < 4; i++) tick(0, 1);
    check("s2_total0", 32'(total_coin), 32'd0);
    check("s2_idle", 32'(busy), 32'd0);

    // Insufficient credit for drink 1
    coin(1);
    sel(1);
    check("s3_sel_reject", 32'(sel_reject), 32'd1);
    check("s3_total", 32'(total_coin), 32'd5);
    tick(0, 0);
    check("s3_reject_pulse", 32'(sel_reject), 32'd0);
    do_cancel(); tick(0, 1);

    // Credit ceiling at 100
    coin(3); coin(2); coin(2); coin(2); coin(2); coin(1);
    check("s4_total95", 32'(total_coin), 32'd95);
    coin(2);
    check("s4_coin_reject", 32'(coin_reject), 32'd1);
    check("s4_total_kept", 32'(total_coin), 32'd95);
    coin(1);
    check("s4_total100", 32'(total_coin), 32'd100);
    do_cancel(); tick(0, 1); tick(0, 1);

    // Credit 17, cancel with same-cycle coin: refund 10,5,1,1
    coin(2); coin(1); coin(0); coin(0);
    step(0, 1, 3, 0, 0, 1, 0, 0);
    check("s5_coin_reject", 32'(coin_reject), 32'd1);
    check("s5_coin10", 32'(chg_coin), 32'd2);
    tick(0, 1);
    check("s5_coin5", 32'(chg_coin), 32'd1);
    tick(0, 1);
    check("s5_coin1a", 32'(chg_coin), 32'd0);
    tick(0, 1);
    check("s5_coin1b", 32'(chg_coin), 32'd0);
    check("s5_total1", 32'(total_coin), 32'd1);
    tick(0, 1);
    check("s5_done", 32'(busy), 32'd0);

    // Reset mid-CHANGE
    coin(2); coin(1); coin(0); coin(0);
    do_cancel(); tick(0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("s6_chg_req", 32'(chg_req), 32'd0);
    check("s6_total", 32'(total_coin), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(199) == 0, $urandom_range(2) == 0, int'($urandom_range(3)),
           $urandom_range(5) == 0, int'($urandom_range(3)), $urandom_range(24) == 0,
           $urandom_range(2) == 0, $urandom_range(1) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Transaction controller for the drink vending datapath.
- Accumulates coin credit and validates drink selections against per-drink prices.
- Sequences the dispenser through a req/ack handshake, then pays change coin-by-coin through the change unit.
- Sits between the front-panel inputs and the dispenser/change-unit actuators.

Parameters:
PRICE0, 10, price of drink 0
PRICE1, 15, price of drink 1
PRICE2, 20, price of drink 2
PRICE3, 25, price of drink 3
MAX_CREDIT, 100, credit ceiling; a coin that would exceed it is rejected
CW, 8, credit/total_coin width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
coin_valid  in  1  one-cycle pulse, coin inserted
coin_type  in  2  00=1, 01=5, 10=10, 11=50
sel_valid  in  1  one-cycle pulse, drink selected
sel_drink  in  2  drink index 0..3
cancel  in  1  one-cycle pulse, refund all credit
disp_req  out  1  dispense request
disp_drink  out  2  drink to dispense, stable while disp_req=1
disp_ack  in  1  dispenser accepted request
chg_req  out  1  change-coin request
chg_coin  out  2  coin to return, same encoding as coin_type
chg_ack  in  1  change unit ejected chg_coin
total_coin  out  CW  current credit
can_buy  out  4  bit i = (total_coin >= PRICEi) && state==IDLE
coin_reject  out  1  one-cycle pulse, coin returned unaccepted
sel_reject  out  1  one-cycle pulse, selection refused
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; total_coin=0; disp_req, chg_req, coin_reject, sel_reject, busy = 0; disp_drink = chg_coin = 0. Reset overrides everything, including mid-handshake.
- Unused PRICEi or coin values are never synthesised away; all arithmetic is unsigned CW bits. Credit never exceeds MAX_CREDIT, so there is no overflow.
- States: IDLE, DISPENSE, CHANGE.
- IDLE, per-cycle priority cancel > sel_valid > coin_valid. A lower-priority event in the same cycle is dropped; a dropped coin pulses coin_reject next cycle.
  - cancel: credit>0 -> CHANGE; credit=0 -> no-op.
  - sel_valid: credit >= PRICE[sel_drink] -> register disp_drink, credit -= price, -> DISPENSE. Otherwise pulse sel_reject (next cycle) and stay in IDLE.
  - coin_valid: credit+value <= MAX_CREDIT -> credit += value, visible on total_coin next cycle. Otherwise coin_reject pulses next cycle and credit is unchanged.
- DISPENSE:
  - disp_req=1 from the first DISPENSE cycle until the cycle disp_ack=1 is sampled.
  - On ack: disp_req clears next cycle; credit>0 -> CHANGE; credit=0 -> IDLE.
  - No timeout.
- CHANGE:
  - chg_req=1 while credit>0. chg_coin = largest denomination <= credit (50, 10, 5, 1 order).
  - On a cycle with chg_req && chg_ack: credit -= coin value, and chg_coin is recomputed next cycle. chg_req may stay high back-to-back.
  - Credit reaches 0 -> chg_req=0, -> IDLE in the same update.
- In DISPENSE and CHANGE: coin_valid pulses coin_reject; sel_valid pulses sel_reject; cancel is ignored.
- ack inputs are ignored when the corresponding req=0.
- total_coin is always the registered credit. It decrements at price acceptance, not at dispense.
- Latency:
  - Selection -> disp_req: 1 cycle.
  - Ack -> next state: 1 cycle.
  - Minimum full vend with change of one coin: select, DISPENSE(ack), CHANGE(ack), IDLE = 3 cycles after select.

Test Plan:
- Coins 10,5,10 then sel_drink=3 -> total_coin 25, can_buy=4'b1111; disp_req with disp_drink=3; after ack, IDLE with total_coin=0, no chg_req.
- Coins 50 then sel_drink=0 with ack in the 3rd req cycle -> disp_req held 3 cycles; then change 10,10,10,10 with chg_ack every cycle; total_coin 40->0; back to IDLE.
- Credit 5, sel_drink=1 -> sel_reject one pulse, state stays IDLE, total_coin=5.
- Credit 95, insert 10 -> coin_reject, total_coin=95; then insert 5 -> total_coin=100.
- Credit 17, cancel -> chg_coin sequence 10,5,1,1; same-cycle cancel+coin -> coin_reject, refund of 17 only.
- reset asserted mid-CHANGE with chg_req=1 -> next cycle chg_req=0, total_coin=0, busy=0.
